// File: rtl/tile_pixel_assembler_if.sv
// Pixel-assembler bus: shifter-side tile inputs plus the registered pixel stream
// toward the line-buffer writer.
interface tile_pixel_assembler_if #(
    parameter int unsigned XW = 10
);
    logic          load_n;
    logic [5:0]    ser_in;
    logic          attr_hflip;
    logic [3:0]    attr_palette;
    logic          attr_prio;
    logic [XW-1:0] x_start;

    logic          pix_valid;
    logic [XW-1:0] pix_x;
    logic [6:0]    pix_color;
    logic          pix_opaque;
    logic          pix_prio;
    logic          tile_done;

    modport master (
        output load_n, ser_in, attr_hflip, attr_palette, attr_prio, x_start,
        input  pix_valid, pix_x, pix_color, pix_opaque, pix_prio, tile_done
    );

    modport slave (
        input  load_n, ser_in, attr_hflip, attr_palette, attr_prio, x_start,
        output pix_valid, pix_x, pix_color, pix_opaque, pix_prio, tile_done
    );
endinterface

// File: rtl/tile_pixel_assembler.sv
// Turns the 3-plane shifter's serial streams into one registered pixel per clock,
// with per-tile flip/palette/priority, screen X tracking and window gating.
module tile_pixel_assembler #(
    parameter int unsigned XW   = 10,
    parameter int unsigned HVIS = 384
) (
    input  logic                   clock,
    input  logic                   reset_n,
    tile_pixel_assembler_if.slave  bus
);

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t        state_q, state_d;
    logic [2:0]    k_q, k_d;
    logic          hflip_q, hflip_d;
    logic [3:0]    pal_q, pal_d;
    logic          prio_q, prio_d;
    logic [XW-1:0] xs_q, xs_d;

    logic          valid_q, valid_d;
    logic [XW-1:0] x_q, x_d;
    logic [6:0]    color_q, color_d;
    logic          opaque_q, opaque_d;
    logic          pprio_q, pprio_d;
    logic          done_q, done_d;

    logic [2:0]    idx;
    logic [XW-1:0] cur_x;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            hflip_q  <= 1'b0;
            pal_q    <= '0;
            prio_q   <= 1'b0;
            xs_q     <= '0;
            valid_q  <= 1'b0;
            x_q      <= '0;
            color_q  <= '0;
            opaque_q <= 1'b0;
            pprio_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            hflip_q  <= hflip_d;
            pal_q    <= pal_d;
            prio_q   <= prio_d;
            xs_q     <= xs_d;
            valid_q  <= valid_d;
            x_q      <= x_d;
            color_q  <= color_d;
            opaque_q <= opaque_d;
            pprio_q  <= pprio_d;
            done_q   <= done_d;
        end
    end

    // A load always wins: it restarts the tile even mid-stream, truncating the old one.
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        hflip_d = hflip_q;
        pal_d   = pal_q;
        prio_d  = prio_q;
        xs_d    = xs_q;
        if (!bus.load_n) begin
            state_d = ST_ACTIVE;
            k_d     = '0;
            hflip_d = bus.attr_hflip;
            pal_d   = bus.attr_palette;
            prio_d  = bus.attr_prio;
            xs_d    = bus.x_start;
        end else if (state_q == ST_ACTIVE) begin
            if (k_q == 3'd7) begin
                state_d = ST_IDLE;
                k_d     = '0;
            end else begin
                k_d = k_q + 3'd1;
            end
        end
    end

    // Pixel sampled at this edge uses the attributes held before any capture at the same edge.
    always_comb begin
        for (int unsigned p = 0; p < 3; p++) begin
            idx[p] = hflip_q ? bus.ser_in[2*p+1] : bus.ser_in[2*p];
        end
        cur_x    = xs_q + XW'(k_q);
        valid_d  = 1'b0;
        x_d      = '0;
        color_d  = '0;
        opaque_d = 1'b0;
        pprio_d  = 1'b0;
        done_d   = 1'b0;
        if (state_q == ST_ACTIVE) begin
            valid_d  = 32'(cur_x) < HVIS;
            x_d      = cur_x;
            color_d  = {pal_q, idx};
            opaque_d = |idx;
            pprio_d  = prio_q;
            done_d   = (k_q == 3'd7);
        end
    end

    assign bus.pix_valid  = valid_q;
    assign bus.pix_x      = x_q;
    assign bus.pix_color  = color_q;
    assign bus.pix_opaque = opaque_q;
    assign bus.pix_prio   = pprio_q;
    assign bus.tile_done  = done_q;

endmodule

// File: tb/tb_tile_pixel_assembler.sv
// Directed bench: a per-edge plan of shifter stimulus and an edge-indexed schedule of
// expected pixels derived from tile-level rules, compared against the DUT every edge.
module tb_tile_pixel_assembler;

    localparam int NE = 215;

    logic clock = 1'b0;
    logic reset_n;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    tile_pixel_assembler_if #(.XW(10)) bus ();

    tile_pixel_assembler #(.XW(10), .HVIS(384)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Stimulus plan, indexed by the edge that samples it.
    bit         ld_n_plan [0:NE+1];
    bit         rst_low   [0:NE+1];
    bit [5:0]   ser_plan  [0:NE+1];
    bit         hf_plan   [0:NE+1];
    bit [3:0]   pal_plan  [0:NE+1];
    bit         pr_plan   [0:NE+1];
    bit [9:0]   xs_plan   [0:NE+1];

    // Expected outputs after each edge.
    bit         e_valid [0:NE+1];
    bit [9:0]   e_x     [0:NE+1];
    bit [6:0]   e_color [0:NE+1];
    bit         e_opaq  [0:NE+1];
    bit         e_prio  [0:NE+1];
    bit         e_done  [0:NE+1];
    bit         e_act   [0:NE+1];

    task automatic check(input string name, input int e, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s edge %0d: got %h expected %h", name, e, act, exp);
        end
    endtask

    task automatic clear_exp(input int from);
        for (int e = from; e <= NE + 1; e++) begin
            e_valid[e] = 0; e_x[e] = 0; e_color[e] = 0;
            e_opaq[e] = 0; e_prio[e] = 0; e_done[e] = 0; e_act[e] = 0;
        end
    endtask

    // Tile loaded at edge e0: pixel k is sampled and shown after edge e0+1+k.
    // Any later pixel of an older tile is superseded by this load.
    task automatic plan_tile(input int e0, input bit [7:0] p1, input bit [7:0] p2, input bit [7:0] p3,
                             input bit hf, input bit [3:0] pal, input bit pr, input bit [9:0] xs);
        bit [2:0] ix;
        bit [9:0] x;
        int e;
        ld_n_plan[e0] = 0;
        hf_plan[e0] = hf; pal_plan[e0] = pal; pr_plan[e0] = pr; xs_plan[e0] = xs;
        clear_exp(e0 + 1);
        for (int k = 0; k < 8; k++) begin
            e = e0 + 1 + k;
            if (e <= NE + 1) begin
                ser_plan[e] = {p3[k], p3[7-k], p2[k], p2[7-k], p1[k], p1[7-k]};
                ix = hf ? {p3[k], p2[k], p1[k]} : {p3[7-k], p2[7-k], p1[7-k]};
                x = xs + 10'(k);
                e_act[e] = 1; e_x[e] = x; e_valid[e] = (x < 384);
                e_color[e] = {pal, ix}; e_opaq[e] = (ix != 0); e_prio[e] = pr;
                e_done[e] = (k == 7);
            end
        end
    endtask

    task automatic plan_reset(input int r, input int len);
        for (int e = r; e < r + len; e++) rst_low[e] = 1;
        clear_exp(r);
    endtask

    function automatic logic [31:0] dut_out();
        return {11'd0, bus.pix_valid, bus.pix_x, bus.pix_color, bus.pix_opaque, bus.pix_prio, bus.tile_done};
    endfunction

    function automatic logic [31:0] exp_out(input int e);
        return {11'd0, e_valid[e], e_x[e], e_color[e], e_opaq[e], e_prio[e], e_done[e]};
    endfunction

    task automatic drive(input int e);
        logic prev;
        int i;
        i = (e > NE + 1) ? NE + 1 : e;
        prev = reset_n;
        reset_n          = !rst_low[i];
        bus.load_n       = ld_n_plan[i];
        bus.ser_in       = ser_plan[i];
        bus.attr_hflip   = hf_plan[i];
        bus.attr_palette = pal_plan[i];
        bus.attr_prio    = pr_plan[i];
        bus.x_start      = xs_plan[i];
        if (prev === 1'b1 && reset_n === 1'b0) begin
            #1;
            check("reset_immediate", e, dut_out(), 32'd0);
        end
    endtask

    // Compare process: every edge, outputs are meaningful (zero when idle).
    initial begin
        forever begin
            @(posedge clock);
            #3;
            if (cyc >= 1 && cyc <= NE) check("pixel", cyc, dut_out(), exp_out(cyc));
        end
    end

    initial begin
        int c1 [8] = '{27, 26, 27, 26, 28, 29, 28, 29};
        int c2 [8] = '{29, 28, 29, 28, 26, 27, 26, 27};
        int v4 [8] = '{1, 1, 1, 1, 0, 0, 0, 0};
        int x5 [8] = '{1022, 1023, 0, 1, 2, 3, 4, 5};
        int v5 [8] = '{0, 0, 1, 1, 1, 1, 1, 1};
        int nd;
        int nv;

        for (int e = 0; e <= NE + 1; e++) begin
            ld_n_plan[e] = 1; rst_low[e] = 0;
            ser_plan[e] = 6'($urandom); hf_plan[e] = 1'($urandom);
            pal_plan[e] = 4'($urandom); pr_plan[e] = 1'($urandom);
            xs_plan[e] = 10'($urandom);
        end
        clear_exp(0);
        rst_low[0] = 1; rst_low[1] = 1; rst_low[2] = 1;

        plan_tile(10, 8'hA5, 8'hF0, 8'h0F, 0, 4'd3, 1, 10'd100);
        plan_tile(30, 8'hA5, 8'hF0, 8'h0F, 1, 4'd3, 0, 10'd100);
        plan_tile(50, 8'h00, 8'h00, 8'h00, 0, 4'd15, 1, 10'd200);
        plan_tile(70, 8'h3C, 8'h99, 8'h5A, 0, 4'd6, 1, 10'd380);
        plan_tile(90, 8'hC3, 8'h0F, 8'hAA, 1, 4'd2, 0, 10'd1022);
        plan_tile(110, 8'h81, 8'h7E, 8'h55, 0, 4'd1, 0, 10'd10);
        plan_tile(118, 8'hF3, 8'h1C, 8'hE7, 0, 4'd2, 1, 10'd18);
        plan_tile(140, 8'hFF, 8'h00, 8'hFF, 0, 4'd4, 1, 10'd300);
        plan_tile(141, 8'h0F, 8'hFF, 8'h00, 1, 4'd5, 0, 10'd20);
        plan_tile(142, 8'hAA, 8'h55, 8'hFF, 0, 4'd6, 1, 10'd30);
        plan_tile(143, 8'h12, 8'h34, 8'h56, 0, 4'd7, 0, 10'd40);
        plan_tile(170, 8'hC3, 8'h66, 8'h18, 0, 4'd5, 1, 10'd60);
        plan_tile(174, 8'hFF, 8'h81, 8'h00, 0, 4'd9, 0, 10'd50);
        plan_reset(176, 2);
        plan_tile(190, 8'hE1, 8'h2D, 8'hB4, 1, 4'd11, 1, 10'd370);

        // Literal pins on the expected schedule.
        for (int k = 0; k < 8; k++) begin
            check("pin_t1_color", 11 + k, 32'(e_color[11+k]), 32'(c1[k]));
            check("pin_t2_color", 31 + k, 32'(e_color[31+k]), 32'(c2[k]));
            check("pin_t3_color", 51 + k, {24'd0, e_opaq[51+k], e_color[51+k]}, 32'd120);
            check("pin_t4_valid", 71 + k, 32'(e_valid[71+k]), 32'(v4[k]));
            check("pin_t5_x", 91 + k, {21'd0, e_valid[91+k], e_x[91+k]}, {21'd0, 1'(v5[k]), 10'(x5[k])});
        end
        check("pin_t1_done", 18, {e_done[18], e_x[18]}, {1'b1, 10'd107});
        check("pin_t4_done", 78, 32'(e_done[78]), 32'd1);
        nd = 0; nv = 0;
        for (int e = 111; e <= 126; e++) begin
            nd += int'(e_done[e]);
            nv += int'(e_valid[e]);
        end
        check("pin_b2b_done", 126, 32'(nd), 32'd2);
        check("pin_b2b_valid", 126, 32'(nv), 32'd16);
        check("pin_b2b_pal", 119, {e_color[118][6:3], e_color[119][6:3]}, {4'd1, 4'd2});
        check("pin_held_x", 144, {e_done[142], e_x[142], e_x[143], e_x[144]}, {1'b0, 10'd20, 10'd30, 10'd40});
        check("pin_reload", 176, {e_act[174], e_x[175], e_color[175][6:3], e_act[176], e_act[189]},
              {1'b1, 10'd50, 4'd9, 1'b0, 1'b0});

        for (int e = 1; e <= NE + 1; e++) begin
            drive(e);
            @(negedge clock);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
